// File: rtl/fixed_predictor_decoder.sv
// fixed_predictor_decoder
// Rebuilds the 16-bit samples of one FLAC FIXED subframe from the residual
// stream. Warm-up samples pass through unchanged. Every later sample is the
// order-N fixed polynomial prediction plus the incoming residual. Each
// accepted input produces one registered output sample one cycle later.
module fixed_predictor_decoder (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iEnable,
    input  logic               iStart,
    input  logic [2:0]         iOrder,
    input  logic [15:0]        iBlockSize,
    input  logic signed [15:0] iData,
    input  logic               iValid,
    output logic signed [15:0] oSample,
    output logic               oValid,
    output logic               oFrameDone,
    output logic               oBusy,
    output logic               oError
);

    localparam int DATA_W = 16;
    localparam int PRED_W = 20;
    localparam int SUM_W  = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        DECODE = 2'd2
    } state_t;

    // Prediction from history. The widest case (order 4) has a coefficient
    // magnitude sum of 15. Twenty bits therefore cover any 16-bit history
    // without overflow.
    function automatic logic signed [PRED_W-1:0] predict(
        input logic [2:0]               n,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] c,
        input logic signed [DATA_W-1:0] d
    );
        logic signed [PRED_W-1:0] x1;
        logic signed [PRED_W-1:0] x2;
        logic signed [PRED_W-1:0] x3;
        logic signed [PRED_W-1:0] x4;
        x1 = PRED_W'(a);
        x2 = PRED_W'(b);
        x3 = PRED_W'(c);
        x4 = PRED_W'(d);
        case (n)
            3'd1:    predict = x1;
            3'd2:    predict = (x1 <<< 1) - x2;
            3'd3:    predict = (x1 <<< 1) + x1 - (x2 <<< 1) - x2 + x3;
            3'd4:    predict = (x1 <<< 2) - (x2 <<< 2) - (x2 <<< 1) + (x3 <<< 2) - x4;
            default: predict = '0;
        endcase
    endfunction

    // The reconstructed sample wraps modulo 2^16. The decoder does not
    // saturate, so that it matches the encoder's integer arithmetic.
    function automatic logic signed [DATA_W-1:0] wrap_sample(
        input logic signed [SUM_W-1:0] x
    );
        wrap_sample = x[DATA_W-1:0];
    endfunction

    state_t                   state_p0;
    state_t                   state_nxt;
    logic [2:0]               order_p0;
    logic [15:0]              block_size_p0;
    logic [15:0]              count_p0;
    logic signed [DATA_W-1:0] s1_p0;
    logic signed [DATA_W-1:0] s2_p0;
    logic signed [DATA_W-1:0] s3_p0;
    logic signed [DATA_W-1:0] s4_p0;

    logic                     start_ok;
    logic                     start_bad;
    logic                     accept;
    logic [16:0]              count_inc;
    logic                     last_sample;
    logic signed [PRED_W-1:0] pred_p0;
    logic signed [SUM_W-1:0]  sum_p0;
    logic signed [DATA_W-1:0] sample_p0;
    logic                     vld_p1_nxt;
    logic                     done_nxt;

    // Decode the handshake qualifiers and form the candidate output sample.
    always_comb begin
        start_ok    = iEnable && iStart && (iOrder <= 3'd4);
        start_bad   = iEnable && iStart && (iOrder > 3'd4);
        // A coincident iStart takes priority, so its iData is dropped.
        accept      = iEnable && iValid && !iStart && (state_p0 != IDLE);
        count_inc   = {1'b0, count_p0} + 17'd1;
        last_sample = (count_inc == {1'b0, block_size_p0});
        pred_p0     = predict(order_p0, s1_p0, s2_p0, s3_p0, s4_p0);
        sum_p0      = SUM_W'(pred_p0) + SUM_W'(iData);
        sample_p0   = (state_p0 == WARMUP) ? iData : wrap_sample(sum_p0);
    end

    // Next-state and pulse generation for the subframe sequencer.
    always_comb begin
        state_nxt  = state_p0;
        vld_p1_nxt = 1'b0;
        done_nxt   = 1'b0;
        if (start_ok) begin
            if (iBlockSize == 16'd0) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else if (iOrder == 3'd0) begin
                state_nxt = DECODE;
            end else begin
                state_nxt = WARMUP;
            end
        end else if (start_bad) begin
            state_nxt = IDLE;
        end else if (accept) begin
            vld_p1_nxt = 1'b1;
            if (last_sample) begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end else if ((state_p0 == WARMUP) && (count_inc == {14'd0, order_p0})) begin
                state_nxt = DECODE;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // ---- p0 -> p1: history, counter and registered outputs ----
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oSample       <= '0;
            oValid        <= 1'b0;
            oFrameDone    <= 1'b0;
            oError        <= 1'b0;
            order_p0      <= '0;
            block_size_p0 <= '0;
            count_p0      <= '0;
            s1_p0         <= '0;
            s2_p0         <= '0;
            s3_p0         <= '0;
            s4_p0         <= '0;
        end else begin
            oValid     <= vld_p1_nxt;
            oFrameDone <= done_nxt;
            if (start_ok) begin
                oError <= 1'b0;
            end else if (start_bad) begin
                oError <= 1'b1;
            end
            if (start_ok) begin
                order_p0      <= iOrder;
                block_size_p0 <= iBlockSize;
                count_p0      <= '0;
                s1_p0         <= '0;
                s2_p0         <= '0;
                s3_p0         <= '0;
                s4_p0         <= '0;
            end else if (accept) begin
                count_p0 <= count_p0 + 16'd1;
                s4_p0    <= s3_p0;
                s3_p0    <= s2_p0;
                s2_p0    <= s1_p0;
                s1_p0    <= sample_p0;
                oSample  <= sample_p0;
            end
        end
    end

    assign oBusy = (state_p0 != IDLE);

endmodule

// File: tb/tb_fixed_predictor_decoder.sv
// Bench for fixed_predictor_decoder. A behavioural model tracks the
// subframe as "active or not", a sample count and a history list. It computes
// predictions from binomial coefficients. Every cycle's outputs are compared
// against that model. Directed scenarios also check literal sample lists.
module tb_fixed_predictor_decoder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b0;
    logic               st  = 1'b0;
    logic [2:0]         ord = '0;
    logic [15:0]        bs  = '0;
    logic signed [15:0] din = '0;
    logic               vld = 1'b0;
    logic signed [15:0] o_sample;
    logic               o_valid;
    logic               o_done;
    logic               o_busy;
    logic               o_error;

    always #5 clk = ~clk;

    fixed_predictor_decoder dut (
        .iClock     (clk),
        .iReset     (rst),
        .iEnable    (en),
        .iStart     (st),
        .iOrder     (ord),
        .iBlockSize (bs),
        .iData      (din),
        .iValid     (vld),
        .oSample    (o_sample),
        .oValid     (o_valid),
        .oFrameDone (o_done),
        .oBusy      (o_busy),
        .oError     (o_error)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit m_active = 0;
    bit m_err    = 0;
    int m_n      = 0;
    int m_blk    = 0;
    int m_cnt    = 0;
    int m_hist[4];
    bit e_valid  = 0;
    bit e_done   = 0;
    int e_sample = 0;

    // Observed-output bookkeeping for the directed checks.
    int got[$];
    int done_cnt    = 0;
    int done_sample = 0;
    bit done_busy   = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wrap16(input int x);
        int y;
        y = x & 32'h0000FFFF;
        if (y >= 32768) y = y - 65536;
        return y;
    endfunction

    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    task automatic model_step();
        int p;
        int v;
        e_valid = 0;
        e_done  = 0;
        if (rst) begin
            m_active = 0; m_err = 0; m_n = 0; m_blk = 0; m_cnt = 0;
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
            e_sample = 0;
        end else if (en) begin
            if (st) begin
                if (int'(ord) > 4) begin
                    m_err    = 1;
                    m_active = 0;
                end else begin
                    m_err = 0;
                    m_n   = int'(ord);
                    m_blk = int'(bs);
                    m_cnt = 0;
                    for (int i = 0; i < 4; i++) m_hist[i] = 0;
                    if (m_blk == 0) begin
                        e_done   = 1;
                        m_active = 0;
                    end else begin
                        m_active = 1;
                    end
                end
            end else if (vld && m_active) begin
                if (m_cnt < m_n) begin
                    v = int'(din);
                end else begin
                    p = 0;
                    for (int k = 1; k <= m_n; k++)
                        p += ((k % 2 == 1) ? 1 : -1) * binom(m_n, k) * m_hist[k-1];
                    v = wrap16(p + int'(din));
                end
                for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = v;
                m_cnt++;
                e_valid  = 1;
                e_sample = v;
                if (m_cnt == m_blk) begin
                    e_done   = 1;
                    m_active = 0;
                end
            end
        end
    endtask

    task automatic compare();
        chk("valid", o_valid, e_valid);
        chk("frame_done", o_done, e_done);
        chk("busy", o_busy, m_active);
        chk("error", o_error, m_err);
        if (e_valid || rst) chk("sample", o_sample, e_sample);
        if (o_valid === 1'b1) got.push_back(int'(o_sample));
        if (o_done === 1'b1) begin
            done_cnt++;
            done_sample = int'(o_sample);
            done_busy   = o_busy;
        end
    endtask

    // Single compare process: advance the model on the edge, check just after.
    always begin
        @(posedge clk);
        model_step();
        #1;
        compare();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit e, input bit s, input int o, input int b,
                         input bit v, input int d);
        en  = e;
        st  = s;
        ord = o[2:0];
        bs  = b[15:0];
        vld = v;
        din = d[15:0];
        @(negedge clk);
    endtask

    task automatic start(input int o, input int b);
        drive(1, 1, o, b, 0, 0);
    endtask

    task automatic feed(input int d);
        drive(1, 0, 0, 0, 1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
    endtask

    task automatic check_queue(input string name, input int exp[$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) chk(name, got[i], exp[i]);
    endtask

    initial begin
        int exp[$];
        int d0;
        repeat (3) @(negedge clk);
        chk("reset_sample", o_sample, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_error", o_error, 0);
        rst = 1'b0;
        idle(2);

        // Order 2 ramp.
        got.delete(); d0 = done_cnt;
        start(2, 5);
        feed(10); feed(20); feed(1); feed(-2); feed(0);
        idle(2);
        exp = '{10, 20, 31, 40, 49};
        check_queue("order2", exp);
        chk("order2_done_count", done_cnt - d0, 1);
        chk("order2_done_sample", done_sample, 49);
        chk("order2_done_busy", done_busy, 0);

        // Order 4 wrap.
        got.delete();
        start(4, 5);
        repeat (4) feed(32767);
        feed(1);
        idle(2);
        exp = '{32767, 32767, 32767, 32767, -32768};
        check_queue("order4_wrap", exp);
        chk("order4_error", o_error, 0);

        // Order 0 pass-through.
        got.delete();
        start(0, 3);
        feed(-5); feed(7); feed(0);
        idle(2);
        exp = '{-5, 7, 0};
        check_queue("order0", exp);

        // Enable gap with iValid held high.
        got.delete();
        start(1, 4);
        feed(5); feed(6);
        repeat (3) drive(0, 0, 0, 0, 1, 99);
        feed(2); feed(3);
        idle(2);
        exp = '{5, 11, 13, 16};
        check_queue("enable_gap", exp);

        // Abort by restart coincident with iValid.
        got.delete(); d0 = done_cnt;
        start(3, 8);
        feed(7); feed(8);
        drive(1, 1, 1, 2, 1, 555);
        feed(100); feed(3);
        idle(2);
        exp = '{7, 8, 100, 103};
        check_queue("abort", exp);
        chk("abort_done_count", done_cnt - d0, 1);

        // Illegal order, then a zero-length subframe.
        got.delete();
        drive(1, 1, 6, 5, 0, 0);
        chk("illegal_error", o_error, 1);
        chk("illegal_busy", o_busy, 0);
        feed(42); feed(43);
        idle(1);
        chk("illegal_no_output", got.size(), 0);
        d0 = done_cnt;
        start(0, 0);
        chk("zero_len_done", o_done, 1);
        chk("zero_len_error", o_error, 0);
        chk("zero_len_busy", o_busy, 0);
        idle(2);
        chk("zero_len_done_count", done_cnt - d0, 1);

        // Randomized subframes.
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            start($urandom_range(0, 7), $urandom_range(0, 12));
            for (int c = 0; c < 80 && o_busy; c++) begin
                int sel;
                int d;
                sel = $urandom_range(0, 3);
                if (sel == 0)      d = 32767;
                else if (sel == 1) d = -32768;
                else if (sel == 2) d = $urandom_range(0, 40) - 20;
                else               d = $urandom_range(0, 65535) - 32768;
                if ($urandom_range(0, 49) == 0)
                    drive($urandom_range(0, 9) != 0, 1, $urandom_range(0, 7),
                          $urandom_range(0, 6), $urandom_range(0, 1), d);
                else
                    drive($urandom_range(0, 9) != 0, 0, 0, 0,
                          $urandom_range(0, 9) < 7, d);
            end
            idle(1);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
